// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//
// ID-stage hazard tracker. It keeps a shadow copy of every register write in
// flight after ID (stage 1 = EX ... stage DEPTH), together with one
// multi-cycle (MUL/DIV) unit. From that state it produces one forward-select
// code per read port and a single pipeline stall.
//
// Handshake semantics: there is no valid/ready pair on this block. The ID
// instruction counts as "issued" when id_valid is high and flush is low. An
// issued instruction is consumed at a rising clock edge only if stall and
// hold are both low. While stall is high, ID must present the same
// instruction again. While hold is high, all tracked state is frozen, but
// fwd_sel and stall still follow the current inputs.
//
// Stage entry: {valid, rd[4:0], kind[1:0]}
//   kind 0 = ALU    result can be forwarded from stage 1 onwards
//   kind 1 = LOAD   result can be forwarded from LOAD_STAGE onwards
//   kind 2 = NOFWD  never forwarded (link writes); readers wait for retire
//   kind 3 = reserved, handled exactly like NOFWD
//
// The multi-cycle result is never forwarded. Readers of its destination,
// writers of its destination, and any further multi-cycle issue all stall
// while the unit is busy. Register x0 never produces a data hazard.
//
// 2^SEL_W must be greater than DEPTH so that every stage index fits in one
// forward-select code.

module hazard_scoreboard #(
  parameter int NRD        = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int LAT_W      = 4,
  parameter int SEL_W      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [NRD*5-1:0]     id_rs,
  input  logic [NRD-1:0]       id_rs_used,
  input  logic [4:0]           id_rd,
  input  logic                 id_we,
  input  logic [1:0]           id_kind,
  input  logic                 id_mc,
  input  logic [LAT_W-1:0]     id_mc_lat,
  input  logic                 flush,
  input  logic                 hold,
  output logic [NRD*SEL_W-1:0] fwd_sel,
  output logic                 stall,
  output logic                 mc_busy,
  output logic                 mc_done
);

  localparam logic [1:0] KIND_ALU  = 2'd0;
  localparam logic [1:0] KIND_LOAD = 2'd1;

  // Shadow pipeline. Array index i holds stage i+1.
  logic [DEPTH-1:0] st_valid_q, st_valid_d;
  logic [4:0]       st_rd_q   [DEPTH];
  logic [4:0]       st_rd_d   [DEPTH];
  logic [1:0]       st_kind_q [DEPTH];
  logic [1:0]       st_kind_d [DEPTH];

  // Multi-cycle unit tracking.
  logic             mc_busy_q, mc_busy_d;
  logic [4:0]       mc_rd_q,   mc_rd_d;
  logic [LAT_W-1:0] cnt_q,     cnt_d;
  logic             mc_done_q, mc_done_d;

  // Issue qualification and hazard terms.
  logic           issue;
  logic           ins_valid;
  logic [NRD-1:0] port_haz;
  logic [NRD-1:0] port_mc_raw;
  logic           mc_waw;
  logic [4:0]     rs_p;
  logic           found_p;

  // An issued instruction enters stage 1 only if it really writes a
  // non-zero register through the regular pipeline.
  assign issue     = id_valid & ~flush;
  assign ins_valid = issue & id_we & (id_rd != 5'd0) & ~id_mc;

  // Forward select per port: the youngest matching stage decides alone.
  always_comb begin
    fwd_sel     = '0;
    port_haz    = '0;
    port_mc_raw = '0;
    rs_p        = '0;
    found_p     = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      rs_p    = id_rs[5*p +: 5];
      found_p = 1'b0;
      if (id_rs_used[p] && (rs_p != 5'd0)) begin
        port_mc_raw[p] = (rs_p == mc_rd_q);
        for (int k = 0; k < DEPTH; k++) begin
          if (!found_p && st_valid_q[k] && (st_rd_q[k] == rs_p)) begin
            found_p = 1'b1;
            if (st_kind_q[k] == KIND_ALU) begin
              fwd_sel[SEL_W*p +: SEL_W] = SEL_W'(k + 1);
            end else if ((st_kind_q[k] == KIND_LOAD) && ((k + 1) >= LOAD_STAGE)) begin
              fwd_sel[SEL_W*p +: SEL_W] = SEL_W'(k + 1);
            end else begin
              // Load too young, or a producer that is never forwarded.
              port_haz[p] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Single pipeline stall; flush kills the ID instruction so it never stalls.
  always_comb begin
    mc_waw = id_we & (id_rd != 5'd0) & (id_rd == mc_rd_q);
    stall  = issue & ((|port_haz) |
                      (mc_busy_q & ((|port_mc_raw) | mc_waw | id_mc)));
  end

  // Shadow pipeline next state: freeze on hold, bubble on stall, else shift.
  always_comb begin
    st_valid_d = st_valid_q;
    for (int k = 0; k < DEPTH; k++) begin
      st_rd_d[k]   = st_rd_q[k];
      st_kind_d[k] = st_kind_q[k];
    end
    if (!hold) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        st_valid_d[k] = st_valid_q[k-1];
        st_rd_d[k]    = st_rd_q[k-1];
        st_kind_d[k]  = st_kind_q[k-1];
      end
      st_valid_d[0] = ins_valid & ~stall;
      st_rd_d[0]    = (ins_valid & ~stall) ? id_rd   : 5'd0;
      st_kind_d[0]  = (ins_valid & ~stall) ? id_kind : 2'd0;
    end
  end

  // Multi-cycle unit next state: countdown, completion pulse, new issue.
  always_comb begin
    mc_busy_d = mc_busy_q;
    mc_rd_d   = mc_rd_q;
    cnt_d     = cnt_q;
    mc_done_d = 1'b0;
    if (!hold) begin
      if (mc_busy_q) begin
        if (cnt_q <= LAT_W'(1)) begin
          mc_busy_d = 1'b0;
          cnt_d     = '0;
          mc_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      // A new issue while busy always stalls, so it cannot collide with
      // the completion above.
      if (issue && id_mc && !stall) begin
        mc_busy_d = 1'b1;
        mc_rd_d   = id_rd;
        cnt_d     = (id_mc_lat == '0) ? LAT_W'(1) : id_mc_lat;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        st_rd_q[k]   <= 5'd0;
        st_kind_q[k] <= 2'd0;
      end
      mc_busy_q <= 1'b0;
      mc_rd_q   <= 5'd0;
      cnt_q     <= '0;
      mc_done_q <= 1'b0;
    end else begin
      st_valid_q <= st_valid_d;
      for (int k = 0; k < DEPTH; k++) begin
        st_rd_q[k]   <= st_rd_d[k];
        st_kind_q[k] <= st_kind_d[k];
      end
      mc_busy_q <= mc_busy_d;
      mc_rd_q   <= mc_rd_d;
      cnt_q     <= cnt_d;
      mc_done_q <= mc_done_d;
    end
  end

  assign mc_busy = mc_busy_q;
  assign mc_done = mc_done_q;

endmodule
